aes_block_packer: RTL and testbench
===================================

Name: aes_block_packer

Overview:
Upstream feeder for the AES Cipher core. It accepts a byte stream over a valid/ready handshake and assembles 128-bit plaintext blocks, with byte 0 in data bits [127:120]. It pads the final partial block and presents complete blocks on a valid/ready block interface whose data drives the cipher's data_in. It is double-buffered: one assembly register and one output hold register, so byte intake continues while a block waits for the cipher.

Parameters:
MSB_FIRST, 1, 1: first byte of a block lands in [127:120]; 0: first byte lands in [7:0].
PAD_ZERO_BYTE, 8'h00, fill value for unused bytes when padding is compiled out.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
in_data  in  8  message byte
in_valid  in  1  in_data valid
in_last  in  1  qualifies the final byte of a message
in_ready  out  1  packer accepts a byte this cycle
blk_data  out  128  assembled block, to cipher data_in
blk_valid  out  1  blk_data valid and stable
blk_last  out  1  block is the final block of a message
blk_nbytes  out  5  message bytes in the block, 0..16; excludes pad
blk_ready  in  1  consumer takes the block this cycle

Behaviour:
- Reset (rst=0, any time, asynchronous): cnt=0, asm=0, hold empty, state=FILL. Outputs: in_ready=0 while in reset, blk_valid=0, blk_data=0, blk_last=0, blk_nbytes=0. Any partial block is discarded. in_ready=1 on the first clock edge after release.
- Byte accept: in_valid & in_ready. The byte is written to slot cnt; cnt increments (4-bit, wraps 15->0 on completion).
- States:
  - FILL: in_ready=1 unless the assembly register holds a complete block not yet transferred.
  - PADBLK: only when the optional feature is enabled; in_ready=0.
  - XFER: internal condition "asm complete". It is not a separate state.
- Block completion happens in either case:
  - the 16th byte is accepted; or
  - in_last is accepted at slot k<15. Slots k+1..15 are filled in the same edge, blk_nbytes=k+1, last flag set.
- Transfer to hold: when asm is complete and (hold empty OR blk_ready&blk_valid in the same cycle), asm moves to hold on the next edge.
  - blk_valid rises the cycle after the completing byte's edge: latency 1 clock.
  - With hold occupied and not draining, asm holds and in_ready=0. Backpressure must never drop or overwrite a byte.
- Hold: blk_data, blk_last and blk_nbytes stay stable while blk_valid=1 and blk_ready=0. blk_valid clears after a handshake unless a new transfer occurs in the same edge.
- Throughput: one byte per clock sustained when blk_ready=1. A new block may be accepted back-to-back with no bubble.
- in_last on the 16th byte: the block completes normally with blk_last=1 and blk_nbytes=16, unless the optional feature requires an extra block.
- in_valid=0 cycles: no state change.
- Simultaneous events: a hold drain and an asm transfer in the same cycle are both legal. The new block appears with blk_valid continuously high.

Optional Feature:
AES_PKCS7_PAD_EN.
- Defined:
  - Padding bytes equal the pad count (16-(k+1)), per PKCS#7.
  - If in_last arrives on the 16th byte, that block has blk_last=0 and blk_nbytes=16. The FSM then enters PADBLK and emits an extra block of sixteen 8'h10 bytes with blk_last=1 and blk_nbytes=0. in_ready stays 0 until that block reaches hold.
- Undefined:
  - Pad bytes equal PAD_ZERO_BYTE.
  - No extra block is produced; PADBLK is unreachable.

Test Plan:
- Reset: 16 bytes 00..0f streamed, blk_ready=1 -> blk_data=00010203...0e0f the cycle after byte 0f accepted, blk_nbytes=16, blk_last=0 (in_last=0).
- Partial: 5 bytes aa..ae with in_last on ae -> zero-pad build: blk_data=aaabacadae followed by 22 hex zeros, nbytes=5, last=1. PKCS7 build: trailing bytes all 0b.
- Backpressure: blk_ready=0, 40 bytes offered continuously -> in_ready drops after byte 32 and blocks 1 and 2 are held unchanged. Raise blk_ready -> blocks emitted in order with no lost bytes.
- Exact-16 last under AES_PKCS7_PAD_EN: 16 bytes, last on 16th -> two blocks: data block (last=0), then 16×8'h10 (last=1, nbytes=0).
- Async reset asserted mid-block after 7 bytes, between clock edges -> blk_valid=0 immediately. The next 16 bytes form a clean block with no stale bytes.
- MSB_FIRST=0: bytes 00..0f -> blk_data=0f0e...0100.

Source files
------------

// File: rtl/aes_block_packer.sv
// rtl/aes_block_packer.sv - byte stream to 128-bit AES plaintext block packer
//
// Purpose: assembles bytes accepted on the in_* handshake into 128-bit blocks,
// pads the final partial block of a message, and presents finished blocks on
// the blk_* handshake. One assembly register feeds one output hold register,
// so byte intake continues while a block waits for the cipher.
//
// Parameters:
//   MSB_FIRST      1: byte 0 of a block lands in [127:120]; 0: byte 0 in [7:0]
//   PAD_ZERO_BYTE  fill value for unused bytes when PKCS#7 padding is off
//
// Configuration macro: AES_PKCS7_PAD_EN
//   defined   - pad bytes carry the pad count; a message ending exactly on a
//               block boundary gets an extra block of sixteen 8'h10 bytes
//   undefined - pad bytes equal PAD_ZERO_BYTE; no extra block
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   in_data     message byte
//   in_valid    in_data valid
//   in_last     final byte of a message
//   in_ready    packer accepts a byte this cycle
//   blk_data    assembled block (cipher data_in)
//   blk_valid   blk_data valid and stable
//   blk_last    block is the final block of a message
//   blk_nbytes  message bytes in the block (0..16), pad excluded
//   blk_ready   consumer takes the block this cycle

module aes_block_packer #(
    parameter bit         MSB_FIRST     = 1'b1,
    parameter logic [7:0] PAD_ZERO_BYTE = 8'h00
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [127:0] blk_data,
    output logic         blk_valid,
    output logic         blk_last,
    output logic [4:0]   blk_nbytes,
    input  logic         blk_ready
);

`ifdef AES_PKCS7_PAD_EN
    localparam bit PKCS7 = 1'b1;
`else
    localparam bit PKCS7 = 1'b0;
`endif

    typedef enum logic {FILL, PADBLK} state_t;

    state_t         state;
    logic           run;        // low during reset, high from the first edge after release
    logic [3:0]     cnt;        // next slot to fill in the assembly register
    logic [127:0]   asm_data;
    logic           asm_full;   // assembly register holds a complete block
    logic           asm_last;
    logic [4:0]     asm_nbytes;

    logic [127:0]   asm_next;
    logic [7:0]     pad_byte;
    logic           accept;
    logic           xfer;
    logic           complete;
    logic           extra_blk;

    function automatic int slot_lsb(input int slot);
        return MSB_FIRST ? (15 - slot) * 8 : slot * 8;
    endfunction

    // The assembly register frees up on the same edge it moves to hold,
    // so a byte can be accepted in that cycle without a bubble.
    assign xfer     = asm_full && (!blk_valid || blk_ready);
    assign in_ready = run && (state == FILL) && (!asm_full || xfer);
    assign accept   = in_valid && in_ready;
    assign complete = accept && ((cnt == 4'd15) || in_last);
    // A message ending on slot 15 still needs a full pad block under PKCS#7.
    assign extra_blk = PKCS7 && in_last && (cnt == 4'd15);

    // PKCS#7 pad value is 16-(cnt+1) = 15-cnt, i.e. the inverted slot count.
    assign pad_byte = PKCS7 ? {4'h0, ~cnt} : PAD_ZERO_BYTE;

    // Write the incoming byte at slot cnt; on in_last fill all later slots
    // with pad in the same edge.
    always_comb begin
        asm_next = asm_data;
        for (int i = 0; i < 16; i++) begin
            if (4'(i) == cnt)
                asm_next[slot_lsb(i) +: 8] = in_data;
            else if (in_last && (4'(i) > cnt))
                asm_next[slot_lsb(i) +: 8] = pad_byte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FILL;
            run        <= 1'b0;
            cnt        <= 4'd0;
            asm_data   <= '0;
            asm_full   <= 1'b0;
            asm_last   <= 1'b0;
            asm_nbytes <= 5'd0;
            blk_data   <= '0;
            blk_valid  <= 1'b0;
            blk_last   <= 1'b0;
            blk_nbytes <= 5'd0;
        end else begin
            run <= 1'b1;

            if (xfer) begin
                blk_data   <= asm_data;
                blk_last   <= asm_last;
                blk_nbytes <= asm_nbytes;
                blk_valid  <= 1'b1;
                asm_full   <= 1'b0;
            end else if (blk_ready) begin
                blk_valid  <= 1'b0;
            end

            // The data block has left assembly; the pad-only block takes its place.
            if (state == PADBLK && xfer) begin
                asm_data   <= {16{8'h10}};
                asm_full   <= 1'b1;
                asm_last   <= 1'b1;
                asm_nbytes <= 5'd0;
                state      <= FILL;
            end

            if (accept) begin
                asm_data <= asm_next;
                if (complete) begin
                    cnt        <= 4'd0;
                    asm_full   <= 1'b1;
                    asm_last   <= in_last && !extra_blk;
                    asm_nbytes <= {1'b0, cnt} + 5'd1;
                    if (extra_blk)
                        state <= PADBLK;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// tb/tb_aes_block_packer.sv - self-checking bench for aes_block_packer

module tb_aes_block_packer;

`ifdef AES_PKCS7_PAD_EN
    localparam bit PKCS = 1'b1;
`else
    localparam bit PKCS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         blk_ready = 1'b1;

    logic         in_ready,   in_ready_l;
    logic [127:0] blk_data,   blk_data_l;
    logic         blk_valid,  blk_valid_l;
    logic         blk_last,   blk_last_l;
    logic [4:0]   blk_nbytes, blk_nbytes_l;

    aes_block_packer #(.MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .blk_data(blk_data),
        .blk_valid(blk_valid), .blk_last(blk_last), .blk_nbytes(blk_nbytes),
        .blk_ready(blk_ready)
    );

    aes_block_packer #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_l), .blk_data(blk_data_l),
        .blk_valid(blk_valid_l), .blk_last(blk_last_l), .blk_nbytes(blk_nbytes_l),
        .blk_ready(blk_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    int bp_mode  = 0;   // 0: ready high, 1: ready low, 2: random
    bit drv_done = 1'b0;

    typedef struct {
        logic [127:0] dr;
        logic [127:0] dl;
        logic         last;
        logic [4:0]   nb;
    } blk_t;

    blk_t       exp_q[$];
    logic [7:0] cur[$];

    typedef struct {
        int           n;
        logic [7:0]   seed;
        logic [4:0]   exp_nb;
        logic         exp_last;
        bit           chk_data;
        logic [127:0] exp_data;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: gather accepted bytes per message, cut into 16-byte blocks.
    task automatic model_accept(input logic [7:0] b, input logic last);
        blk_t       e;
        logic [7:0] arr[16];
        logic [7:0] pad;
        int         n;
        cur.push_back(b);
        if (last || cur.size() == 16) begin
            n   = cur.size();
            pad = PKCS ? 8'(16 - n) : 8'h00;
            for (int i = 0; i < 16; i++) arr[i] = (i < n) ? cur[i] : pad;
            e.dr = '0;
            e.dl = '0;
            for (int i = 0; i < 16; i++) begin
                e.dr = {e.dr[119:0], arr[i]};
                e.dl = {arr[i], e.dl[127:8]};
            end
            e.last = last && !(PKCS && n == 16);
            e.nb   = 5'(n);
            exp_q.push_back(e);
            if (PKCS && last && n == 16) begin
                e.dr   = {16{8'h10}};
                e.dl   = {16{8'h10}};
                e.last = 1'b1;
                e.nb   = 5'd0;
                exp_q.push_back(e);
            end
            cur.delete();
        end
    endtask

    logic         prev_stall = 1'b0;
    logic [127:0] prev_data;
    logic         prev_last;
    logic [4:0]   prev_nb;

    always @(negedge clk) begin
        blk_t e;
        if (!rst) begin
            cur.delete();
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", blk_valid, 1'b1);
                chk("hold_data", blk_data, prev_data);
                chk("hold_meta", {blk_last, blk_nbytes}, {prev_last, prev_nb});
            end
            chk("pair_ctrl", {in_ready_l, blk_valid_l}, {in_ready, blk_valid});
            if (in_valid && in_ready) begin
                acc_cnt++;
                model_accept(in_data, in_last);
            end
            if (blk_valid && blk_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_blk", blk_data, 'x);
                end else begin
                    e = exp_q.pop_front();
                    chk("blk_data", blk_data, e.dr);
                    chk("blk_data_lsb", blk_data_l, e.dl);
                    chk("blk_meta", {blk_last, blk_nbytes}, {e.last, e.nb});
                end
            end
            prev_stall = blk_valid && !blk_ready;
            prev_data  = blk_data;
            prev_last  = blk_last;
            prev_nb    = blk_nbytes;
        end
    end

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       blk_ready = 1'b1;
            1:       blk_ready = 1'b0;
            default: blk_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic send_byte(input logic [7:0] d, input logic last);
        int t = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            t++;
            if (t > 500) begin
                chk("send_timeout", 1'b1, 1'b0);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] seed, input int n, input logic last);
        for (int j = 0; j < n; j++) send_byte(8'(seed + j), last && (j == n - 1));
    endtask

    task automatic wait_valid();
        int t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!blk_valid && t < 50);
        chk("wait_valid", blk_valid, 1'b1);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || blk_valid) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int   t;
        int   acc0;
        int   len;
        logic [7:0] p5;
        logic [7:0] p1;

        p5 = PKCS ? 8'h0b : 8'h00;
        p1 = PKCS ? 8'h0f : 8'h00;
        vt[0] = '{5,  8'haa, 5'd5,  1'b1,  1'b1, {40'haaabacadae, {11{p5}}}};
        vt[1] = '{1,  8'h3c, 5'd1,  1'b1,  1'b1, {8'h3c, {15{p1}}}};
        vt[2] = '{15, 8'h10, 5'd15, 1'b1,  1'b0, 128'h0};
        vt[3] = '{16, 8'h40, 5'd16, !PKCS, 1'b1, 128'h404142434445464748494a4b4c4d4e4f};

        // Reset values
        #3;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_blk_valid", blk_valid, 1'b0);
        chk("rst_blk_data", blk_data, 128'h0);
        chk("rst_blk_meta", {blk_last, blk_nbytes}, 6'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("rel_in_ready", in_ready, 1'b1);

        // Full block 00..0f, both byte orders
        send_seq(8'h00, 16, 1'b0);
        wait_valid();
        chk("t1_data", blk_data, 128'h000102030405060708090a0b0c0d0e0f);
        chk("t1_data_lsb", blk_data_l, 128'h0f0e0d0c0b0a09080706050403020100);
        chk("t1_meta", {blk_last, blk_nbytes}, {1'b0, 5'd16});
        repeat (4) @(posedge clk);
        #1;

        // Table of message-ending cases
        for (int r = 0; r < 4; r++) begin
            send_seq(vt[r].seed, vt[r].n, 1'b1);
            wait_valid();
            chk("vec_nbytes", blk_nbytes, vt[r].exp_nb);
            chk("vec_last", blk_last, vt[r].exp_last);
            if (vt[r].chk_data) chk("vec_data", blk_data, vt[r].exp_data);
            repeat (6) @(posedge clk);
            #1;
        end
        drain();

        // Backpressure: 40 bytes against a stalled consumer
        bp_mode   = 1;
        blk_ready = 1'b0;
        acc0      = acc_cnt;
        drv_done  = 1'b0;
        fork
            begin
                send_seq(8'h80, 40, 1'b1);
                drv_done = 1'b1;
            end
        join_none
        repeat (60) @(posedge clk);
        #1;
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_accepted", acc_cnt - acc0, 32);
        chk("bp_valid", blk_valid, 1'b1);
        chk("bp_blk1", blk_data, 128'h808182838485868788898a8b8c8d8e8f);
        bp_mode = 2;
        t = 0;
        while (!drv_done && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("bp_driver_done", drv_done, 1'b1);
        #1;
        drain();
        chk("bp_total", acc_cnt - acc0, 40);

        // Asynchronous reset between edges with a held block and 7 bytes in assembly
        bp_mode   = 1;
        blk_ready = 1'b0;
        send_seq(8'h60, 16, 1'b0);
        send_seq(8'h70, 7, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_valid", blk_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_data", blk_data, 128'h0);
        exp_q.delete();
        cur.delete();
        bp_mode   = 0;
        blk_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_seq(8'h20, 16, 1'b0);
        wait_valid();
        chk("arst_clean_blk", blk_data, 128'h202122232425262728292a2b2c2d2e2f);
        chk("arst_clean_meta", {blk_last, blk_nbytes}, {1'b0, 5'd16});
        drain();

        // Randomized messages with idle gaps and random consumer stalls
        bp_mode = 2;
        for (int m = 0; m < 30; m++) begin
            len = $urandom_range(1, 40);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                send_byte(8'($urandom), j == len - 1);
            end
        end
        drain();
        chk("rand_no_partial", cur.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
